// File: rtl/divarb_pkg.sv
// Shared constants for the two-requester divider arbiter: state encoding,
// requester count, the number of WAIT cycles blanked after a divider start,
// and the default timeout length.
package divarb_pkg;

    localparam int NUM_REQ            = 2;
    localparam int BLANK_CYCLES       = 2;
    localparam int DEF_TIMEOUT_CYCLES = 48;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Requester id to one-hot requester mask.
    function automatic logic [NUM_REQ-1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/divarb_rr_pick.sv
// Round-robin pick between the two requesters: a lone requester wins
// outright, contention is resolved in favour of the pointer requester.
module divarb_rr_pick
    import divarb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    // One-hot grant; all-zero when nobody asks.
    always_comb begin
        o_grant = i_req_valid;
        if (&i_req_valid) o_grant = id_onehot(i_ptr);
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between two requesters.
// IDLE accepts one operation, START pulses the divider, WAIT collects the
// result (ignoring div_ready for the first cycles, where it may still show
// the previous operation's completion), RESP holds the response until the
// owning requester takes it.
// Optional feature macro: DIVARB_TIMEOUT_EN adds a WAIT timeout and the
// rsp_timeout output.
module div_arbiter
    import divarb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
`ifdef DIVARB_TIMEOUT_EN
    output logic        rsp_timeout,
`endif
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_result,
    input  logic        div_overflow,
    input  logic        div_ready,
    output logic        busy
);

    // Wait counter is sized for the longer of blanking and timeout; without
    // the timeout it only ever saturates at the blanking count.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > BLANK_CYCLES) ? TIMEOUT_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [1:0]    r_state;
    logic          r_ptr;
    logic          r_id;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_res;
    logic          r_ovf;
    logic [CW-1:0] r_wcnt;
`ifdef DIVARB_TIMEOUT_EN
    logic          r_tmo;
`endif

    logic [1:0]    w_grant;
    logic          w_accept;
    logic          w_qual;
    logic [31:0]   w_sel_a;
    logic [31:0]   w_sel_b;

    divarb_rr_pick u_pick (
        .i_req_valid (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant)
    );

    // Accept path and qualified divider completion.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && !reset && (|w_grant);
        w_sel_a  = w_grant[1] ? req_a[63:32] : req_a[31:0];
        w_sel_b  = w_grant[1] ? req_b[63:32] : req_b[31:0];
        w_qual   = div_ready && (r_wcnt >= CW'(BLANK_CYCLES));
    end

    // Handshake and status outputs decoded from state; req_ready is also
    // gated by reset so it stays low for the whole reset pulse.
    always_comb begin
        req_ready    = ((r_state == ST_IDLE) && !reset) ? w_grant : 2'b00;
        rsp_valid    = (r_state == ST_RESP) ? id_onehot(r_id) : 2'b00;
        div_start    = (r_state == ST_START);
        busy         = (r_state != ST_IDLE);
        div_a        = r_a;
        div_b        = r_b;
        rsp_result   = r_res;
        rsp_overflow = r_ovf;
`ifdef DIVARB_TIMEOUT_EN
        rsp_timeout  = r_tmo;
`endif
    end

    // Main FSM: accept, start, wait for the divider, hold the response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
            r_wcnt  <= '0;
`ifdef DIVARB_TIMEOUT_EN
            r_tmo   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_grant[1];
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_wcnt  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_qual) begin
                        r_res   <= div_result;
                        r_ovf   <= div_overflow;
`ifdef DIVARB_TIMEOUT_EN
                        r_tmo   <= 1'b0;
`endif
                        r_state <= ST_RESP;
                    end
`ifdef DIVARB_TIMEOUT_EN
                    else if (r_wcnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_res   <= '0;
                        r_ovf   <= 1'b1;
                        r_tmo   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_wcnt  <= r_wcnt + 1'b1;
                    end
`else
                    else if (r_wcnt < CW'(BLANK_CYCLES)) begin
                        r_wcnt  <= r_wcnt + 1'b1;
                    end
`endif
                end
                default: begin
                    // ST_RESP: only the pending requester's rsp_ready counts.
                    if (rsp_ready[r_id]) begin
                        r_ptr   <= ~r_id;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 48: WAIT-state cycles before a timeout response; used only when DIVARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  bit n means requester n presents an operation.
REQ-005 SHALL have port req_ready  output  2  bit n means requester n's operation is accepted this cycle when req_valid[n] is also high.
REQ-006 SHALL have port req_a  input  64  dividends; requester n at bits [32n+31:32n].
REQ-007 SHALL have port req_b  input  64  divisors; same packing as req_a.
REQ-008 SHALL have port rsp_valid  output  2  bit n means the response for requester n is presented.
REQ-009 SHALL have port rsp_ready  input  2  bit n means requester n takes its response.
REQ-010 SHALL have port rsp_result  output  32  quotient for the pending requester.
REQ-011 SHALL have port rsp_overflow  output  1  divide-by-zero flag for the pending requester.
REQ-012 SHALL have port rsp_timeout  output  1  timeout flag; present only when DIVARB_TIMEOUT_EN is defined.
REQ-013 SHALL have port div_start  output  1  drives the divider's div input.
REQ-014 SHALL have ports div_a and div_b  output  32 each  divider operand A and operand B.
REQ-015 SHALL have ports div_result  input  32, div_overflow  input  1, div_ready  input  1  divider outputs.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, START, WAIT and RESP.
REQ-018 In IDLE, SHALL assert req_ready only for the granted requester: the one with req_valid high, or the priority-pointer requester when both are high; req_ready SHALL be 0 in all other states.
REQ-019 On acceptance, SHALL latch the operands and the requester id, then go to START.
REQ-020 In START, SHALL assert div_start for exactly one cycle, then go to WAIT.
REQ-021 SHALL drive div_a and div_b from the latched operands, held stable from START through the exit from RESP.
REQ-022 In WAIT, SHALL ignore div_ready for the first 2 cycles (stale counter blanking).
REQ-023 After the blanking cycles, the first cycle with div_ready high SHALL latch div_result and div_overflow, then go to RESP.
REQ-024 In RESP, SHALL assert rsp_valid[id] only and hold rsp_result and rsp_overflow constant until rsp_ready[id] is high.
REQ-025 On the RESP handshake, SHALL return to IDLE and set the priority pointer to the other requester.
REQ-026 SHALL ignore rsp_ready for the non-pending requester.
REQ-027 SHALL not accept a new request in the cycle of a RESP handshake; the next acceptance is no earlier than the following IDLE cycle.
REQ-028 SHALL pass the divider quotient through unmodified; a divisor of 0 yields rsp_overflow=1 with rsp_result as returned by the divider.

Reset
REQ-029 While reset is high, SHALL set state IDLE, priority pointer 0, req_ready 0, rsp_valid 0, div_start 0, rsp_result 0, rsp_overflow 0, rsp_timeout 0 (if present) and busy 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation and issue no response.

Configuration
REQ-031 With DIVARB_TIMEOUT_EN defined, SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES without qualified div_ready, SHALL go to RESP with rsp_result 0, rsp_overflow 1, rsp_timeout 1.
REQ-032 With DIVARB_TIMEOUT_EN undefined, SHALL have no timeout counter and no rsp_timeout port, and WAIT SHALL last until div_ready.

Structure
REQ-033 Package divarb_pkg SHALL hold the state encoding, requester count 2, blanking count 2 and the default TIMEOUT_CYCLES.
REQ-034 Round-robin selection SHALL be a sub-module divarb_rr_pick: inputs req_valid and pointer, output one-hot grant.

Verification
REQ-035 Bench SHALL cover req0 100/7 with the real divider -> rsp_valid[0], rsp_result 14, rsp_overflow 0, within 32-36 cycles of acceptance.
REQ-036 Bench SHALL cover req1 -100/7 -> rsp_result 0xFFFFFFF2 on rsp_valid[1] only.
REQ-037 Bench SHALL cover both requesters valid in the first cycle after reset -> req0 served first, then req1; repeated simultaneous requests alternate.
REQ-038 Bench SHALL cover 5/0 -> rsp_overflow 1; with rsp_ready low for 10 cycles, response held stable and req_ready 2'b00.
REQ-039 Bench SHALL cover reset pulsed in WAIT -> no rsp_valid, busy 0 next cycle, next request served normally.
REQ-040 Bench SHALL cover, with DIVARB_TIMEOUT_EN defined, div_ready stuck low -> response after 48 WAIT cycles with rsp_timeout 1, rsp_overflow 1, rsp_result 0.
